// File: rtl/v0_display_driver.sv
// v0_display_driver: latches a 32-bit value and scans one 16-bit half onto a 4-digit 7-seg display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1 of the shown half.
module v0_display_driver #(
    parameter int CLK_DIV        = 50000,
    parameter int PAGE_SCANS     = 256,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [31:0] value_in,
    input  logic        value_valid_in,
    input  logic        page_mode_in,
    input  logic        page_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_out,
    output logic        page_out,
    output logic        value_ack_out
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int FW = $clog2(PAGE_SCANS + 1);
    localparam logic [6:0] ZERO_GLYPH = (SEG_ACTIVE_LOW != 0) ? 7'h40 : 7'h3F;
    localparam logic [6:0] BLANK      = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    function automatic logic [6:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0: hex_code = 7'h3F;
            4'h1: hex_code = 7'h06;
            4'h2: hex_code = 7'h5B;
            4'h3: hex_code = 7'h4F;
            4'h4: hex_code = 7'h66;
            4'h5: hex_code = 7'h6D;
            4'h6: hex_code = 7'h7D;
            4'h7: hex_code = 7'h07;
            4'h8: hex_code = 7'h7F;
            4'h9: hex_code = 7'h6F;
            4'hA: hex_code = 7'h77;
            4'hB: hex_code = 7'h7C;
            4'hC: hex_code = 7'h39;
            4'hD: hex_code = 7'h5E;
            4'hE: hex_code = 7'h79;
            default: hex_code = 7'h71;
        endcase
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   disp_q, disp_d, shadow_q, shadow_d;
    logic          pending_q, pending_d, page_q, page_d, ack_q, ack_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [3:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick, boundary, last_frame, blank;
    logic [15:0]   half;
    logic [3:0]    nibble;
    logic [6:0]    glyph;

    always_comb begin
        tick       = cnt_q == CW'(CLK_DIV - 1);
        boundary   = tick && idx_q == 2'd3;
        last_frame = frame_q == FW'(PAGE_SCANS - 1);
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        // The boundary only ever moves the pre-edge shadow; a same-cycle load stays pending.
        disp_d     = (boundary && pending_q) ? shadow_q : disp_q;
        shadow_d   = value_valid_in ? value_in : shadow_q;
        pending_d  = value_valid_in | (pending_q & ~boundary);
        ack_d      = boundary & pending_q;
        page_d     = !boundary ? page_q : page_mode_in ? page_in : (last_frame ? ~page_q : page_q);
        frame_d    = !boundary ? frame_q : (page_mode_in || last_frame) ? '0 : frame_q + FW'(1);
        half       = page_d ? disp_d[31:16] : disp_d[15:0];
        nibble     = half[{idx_d, 2'b00} +: 4];
        glyph      = hex_code(nibble);
`ifdef LEADING_ZERO_BLANK_EN
        blank      = (idx_d != 2'd0) && ((half >> {idx_d, 2'b00}) == 16'h0);
`else
        blank      = 1'b0;
`endif
        digit_d    = tick ? 4'b0001 << idx_d : digit_q;
        seg_d      = !tick ? seg_q : blank ? BLANK : (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            page_q    <= 1'b0;
            frame_q   <= '0;
            digit_q   <= 4'b0001;
            seg_q     <= ZERO_GLYPH;
            ack_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            page_q    <= page_d;
            frame_q   <= frame_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            ack_q     <= ack_d;
        end
    end

    assign seg_out       = seg_q;
    assign digit_out     = digit_q;
    assign page_out      = page_q;
    assign value_ack_out = ack_q;
endmodule

// File: tb/tb_v0_display_driver.sv
// tb_v0_display_driver: randomized and directed checks of v0_display_driver against a frame-level model.
module tb_v0_display_driver;
    localparam int CD = 4;
    localparam int PS = 2;
    localparam int FRAME = 4 * CD;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic [31:0] value_in = '0;
    logic        value_valid_in = 1'b0;
    logic        page_mode_in = 1'b0;
    logic        page_in = 1'b0;
    logic [6:0]  seg_out;
    logic [3:0]  digit_out;
    logic        page_out;
    logic        value_ack_out;

    v0_display_driver #(.CLK_DIV(CD), .PAGE_SCANS(PS), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .reset_in(reset_in), .value_in(value_in), .value_valid_in(value_valid_in),
        .page_mode_in(page_mode_in), .page_in(page_in), .seg_out(seg_out),
        .digit_out(digit_out), .page_out(page_out), .value_ack_out(value_ack_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: edges counted since reset release; everything else follows from that count.
    int          mn;
    logic [31:0] m_sh, m_disp;
    bit          m_pend, m_page, m_ack;
    int          m_fc;

    task automatic model_reset();
        mn = 0; m_sh = '0; m_disp = '0; m_pend = 0; m_page = 0; m_ack = 0; m_fc = 0;
    endtask

    function automatic logic [6:0] exp_seg();
        int idx = (mn / CD) % 4;
        int half = m_page ? int'(m_disp[31:16]) : int'(m_disp[15:0]);
        int nib = (half >> (4 * idx)) & 15;
        bit blk = 0;
`ifdef LEADING_ZERO_BLANK_EN
        blk = idx > 0 && (half >> (4 * idx)) == 0;
`endif
        return blk ? 7'h7F : ~hex_tab[nib];
    endfunction

    task automatic step(input bit v, input logic [31:0] val);
        bit bnd;
        value_valid_in = v;
        value_in = val;
        @(posedge clk);
        mn++;
        bnd = (mn % FRAME) == 0;
        m_ack = bnd && m_pend;
        if (bnd) begin
            if (m_pend) begin m_disp = m_sh; m_pend = 0; end
            if (page_mode_in) begin m_page = page_in; m_fc = 0; end
            else if (m_fc == PS - 1) begin m_page = ~m_page; m_fc = 0; end
            else m_fc++;
        end
        if (v) begin m_sh = val; m_pend = 1; end
        @(negedge clk);
        check("digit", digit_out, 32'(4'b0001 << ((mn / CD) % 4)));
        check("seg", seg_out, exp_seg());
        check("page", page_out, m_page);
        check("ack", value_ack_out, m_ack);
        value_valid_in = 1'b0;
    endtask

    task automatic expect_slots(input string tag, input logic [6:0] e0, e1, e2, e3);
        logic [6:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            int b = 0;
            while (digit_out !== 4'(1 << k) && b < FRAME + 1) begin step(0, '0); b++; end
            check({tag, "_found"}, digit_out, 32'(4'b0001 << k));
            check(tag, seg_out, e[k]);
        end
    endtask

    initial begin
        int b, acks, lows;
        model_reset();
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        // 1: asynchronous reset mid-scan
        repeat (7) step(0, '0);
        #2 reset_in = 1'b0;
        #1;
        check("rst_digit", digit_out, 4'b0001);
        check("rst_seg", seg_out, 7'h40);
        check("rst_page", page_out, 1'b0);
        check("rst_ack", value_ack_out, 1'b0);
        @(negedge clk);
        reset_in = 1'b1;
        model_reset();
        // 2: load mid-frame, ack one cycle after the next boundary
        repeat (3) step(0, '0);
        step(1, 32'h1234ABCD);
        b = 0;
        while (value_ack_out !== 1'b1 && b < 3 * FRAME) begin step(0, '0); b++; end
        check("ack2_seen", value_ack_out, 1'b1);
        check("ack2_phase", mn % FRAME, 0);
        expect_slots("t2", ~7'h5E, ~7'h39, ~7'h7C, ~7'h77);
        // 3: auto page toggle after PS frames
        b = 0;
        while (page_out !== 1'b1 && b < 4 * FRAME) begin step(0, '0); b++; end
        check("pg3_seen", page_out, 1'b1);
        check("pg3_edge", mn, 2 * FRAME);
        expect_slots("t3", ~7'h66, ~7'h4F, ~7'h5B, ~7'h06);
        // 4: two loads in one frame -> one ack, last value wins
        while (mn % FRAME != 1) step(0, '0);
        step(1, 32'h11111111);
        step(0, '0);
        step(1, 32'h22222222);
        acks = 0;
        repeat (2 * FRAME) begin step(0, '0); acks += int'(value_ack_out); end
        check("t4_acks", acks, 1);
        expect_slots("t4", ~7'h5B, ~7'h5B, ~7'h5B, ~7'h5B);
        // 5: load on the boundary tick defers to the following boundary
        while (mn % FRAME != FRAME - 1) step(0, '0);
        step(1, 32'hCAFE0005);
        check("t5_noack", value_ack_out, 1'b0);
        acks = 0;
        repeat (FRAME) begin step(0, '0); acks += int'(value_ack_out); end
        check("t5_acks", acks, 1);
        // 6: manual page holds; leading-zero display
        page_mode_in = 1'b1;
        page_in = 1'b1;
        step(0, '0);
        while (mn % FRAME != 0) step(0, '0);
        check("t6_page", page_out, 1'b1);
        lows = 0;
        repeat (10 * FRAME) begin step(0, '0); lows += int'(!page_out); end
        check("t6_hold", lows, 0);
        page_in = 1'b0;
        step(1, 32'h00000007);
        repeat (2 * FRAME) step(0, '0);
`ifdef LEADING_ZERO_BLANK_EN
        expect_slots("t6", ~7'h07, 7'h7F, 7'h7F, 7'h7F);
`else
        expect_slots("t6", ~7'h07, ~7'h3F, ~7'h3F, ~7'h3F);
`endif
        // random traffic
        page_mode_in = 1'b0;
        repeat (2500) begin
            if ($urandom_range(63) == 0) page_mode_in = ~page_mode_in;
            page_in = 1'($urandom_range(1));
            step($urandom_range(7) == 0, $urandom());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
